// File: rtl/vpu_mem_pkg.sv
// Shared types and helpers for the VPU lane-banked memories.
package vpu_mem_pkg;

  typedef enum logic {READY = 1'b0, CLEAR = 1'b1} vbram_state_e;

  localparam int unsigned VBRAM_LANES      = 4;
  localparam int unsigned VBRAM_LANE_WIDTH = 8;
  localparam int unsigned VBRAM_DATA_WIDTH = VBRAM_LANES * VBRAM_LANE_WIDTH;

  // Upper bounds so lane_mask can serve every instance width.
  localparam int unsigned VBRAM_MAX_LANES = 32;
  localparam int unsigned VBRAM_MAX_DW    = 1024;

  function automatic logic [VBRAM_MAX_DW-1:0] lane_mask(
    input logic [VBRAM_MAX_LANES-1:0] lane_en,
    input int unsigned                lanes,
    input int unsigned                lane_width
  );
    logic [VBRAM_MAX_DW-1:0]    mask;
    logic [VBRAM_MAX_DW-1:0]    lane_ones;
    logic [VBRAM_MAX_LANES-1:0] en;
    mask      = '0;
    en        = lane_en;
    lane_ones = (VBRAM_MAX_DW'(1) << lane_width) - VBRAM_MAX_DW'(1);
    for (int unsigned l = 0; l < VBRAM_MAX_LANES; l++) begin
      if (l < lanes && en[0])
        mask |= lane_ones << (l * lane_width);
      en = en >> 1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/vbram_clear_ctrl.sv
// Clear-sweep controller: walks every address once, writing zero, then returns to READY.
module vbram_clear_ctrl
  import vpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_we,
  output logic [ADDR_WIDTH-1:0] clear_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  vbram_state_e          state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
    else        state <= state_nxt;
  end

  // Counter wraps to zero on the final sweep write, ready for the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (state == CLEAR) cnt <= cnt + 1'b1;
    else                     cnt <= '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      READY:   if (clear_req)        state_nxt = CLEAR;
      CLEAR:   if (cnt == LAST_ADDR) state_nxt = READY;
      default: state_nxt = READY;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    clear_we   = 1'b0;
    clear_addr = cnt;
    if (state == CLEAR) begin
      busy     = 1'b1;
      clear_we = 1'b1;
    end
  end

endmodule

// File: rtl/vector_bank_ram.sv
// Lane-banked 1W/1R RAM with write-first forwarding and a hardware clear sweep.
// Define VBRAM_OUT_REG_EN for a second output register stage (read latency 2).
module vector_bank_ram
  import vpu_mem_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH     = 8,
  parameter  int unsigned LANES          = 4,
  parameter  int unsigned LANE_WIDTH     = 8,
  parameter  int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned DATA_WIDTH     = LANES * LANE_WIDTH,
  localparam int unsigned DEPTH          = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [LANES-1:0]      wr_lane_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clear_req,
  output logic                  busy
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] wr_mask, fwd_mask;
  logic                  wr_go, rd_go;
  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic [DATA_WIDTH-1:0] rd_data_s1;
  logic                  rd_valid_s1;

  vbram_clear_ctrl #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (clear_req),
    .busy       (busy),
    .clear_we   (clear_we),
    .clear_addr (clear_addr)
  );

  // A clear request in READY takes priority and drops that cycle's access.
  assign wr_go = wr_en && !busy && !clear_req;
  assign rd_go = rd_en && !busy && !clear_req;

  always_comb begin
    wr_mask  = DATA_WIDTH'(lane_mask(VBRAM_MAX_LANES'(wr_lane_en), LANES, LANE_WIDTH));
    fwd_mask = '0;
    if (wr_go && (wr_addr == rd_addr))
      fwd_mask = wr_mask;
  end

  always_ff @(posedge clk) begin
    if (clear_we)
      mem[clear_addr] <= '0;
    else if (wr_go)
      mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_s1  <= '0;
      rd_valid_s1 <= 1'b0;
    end else begin
      rd_valid_s1 <= rd_go;
      if (rd_go)
        rd_data_s1 <= (mem[rd_addr] & ~fwd_mask) | (wr_data & fwd_mask);
    end
  end

`ifdef VBRAM_OUT_REG_EN
  // Stage 2 advances unconditionally so a read in flight survives a clear start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_valid_s1;
      if (rd_valid_s1)
        rd_data <= rd_data_s1;
    end
  end
`else
  assign rd_data  = rd_data_s1;
  assign rd_valid = rd_valid_s1;
`endif

endmodule

// File: tb/tb_vector_bank_ram.sv
// Self-checking bench for vector_bank_ram (ADDR_WIDTH=4, 4 x 8-bit lanes).
module tb_vector_bank_ram;

  localparam int AW    = 4;
  localparam int LN    = 4;
  localparam int LW    = 8;
  localparam int DW    = LN * LW;
  localparam int DEPTH = 2 ** AW;
`ifdef VBRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [LN-1:0] wr_lane_en = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          clear_req = 1'b0;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  int            clr_left;
  logic          s1_v, out_v;
  logic [DW-1:0] s1_d, out_d;

  always #5 clk = ~clk;

  vector_bank_ram #(
    .ADDR_WIDTH     (AW),
    .LANES          (LN),
    .LANE_WIDTH     (LW),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_lane_en (wr_lane_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .clear_req  (clear_req),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_lane_en = '0; wr_data = '0; wr_addr = '0;
    rd_en = 1'b0; rd_addr = '0; clear_req = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    clr_left = DEPTH;
    s1_v = 1'b0; s1_d = '0; out_v = 1'b0; out_d = '0;
  endtask

  // One clock: update the reference at the edge, compare outputs at the following negedge.
  task automatic cycle();
    logic          nv;
    logic [DW-1:0] nd;
    @(posedge clk);
    nv = 1'b0;
    nd = '0;
    if (clr_left == 0) begin
      if (clear_req) begin
        clr_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end else begin
        if (wr_en)
          for (int l = 0; l < LN; l++)
            if (wr_lane_en[l]) ref_mem[wr_addr][l*LW +: LW] = wr_data[l*LW +: LW];
        if (rd_en) begin
          nv = 1'b1;
          nd = ref_mem[rd_addr];
        end
      end
    end else begin
      clr_left--;
    end
    if (LAT == 2) begin
      out_v = s1_v;
      if (s1_v) out_d = s1_d;
      s1_v = nv;
      if (nv) s1_d = nd;
    end else begin
      out_v = nv;
      if (nv) out_d = nd;
    end
    @(negedge clk);
    check("busy", 32'(busy), 32'(clr_left > 0));
    check("rd_valid", 32'(rd_valid), 32'(out_v));
    check("rd_data", rd_data, out_d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", rd_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_sweep(input string tag);
    int bc = 0;
    while (busy && bc < 40) begin
      cycle();
      bc++;
    end
    check(tag, 32'(bc), 32'(DEPTH));
  endtask

  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LN-1:0] le);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_lane_en = le;
    cycle();
    idle();
  endtask

  task automatic read_word(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
    rd_en = 1'b1; rd_addr = a;
    cycle();
    idle();
    for (int i = 1; i < LAT; i++) cycle();
    d = rd_data;
    v = rd_valid;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic          v;
    logic [DW-1:0] log_d [8];
    logic          log_v [8];

    idle();
    @(negedge clk);
    do_reset();
    wait_sweep("reset_sweep_len");

    for (int a = 0; a < DEPTH; a++) begin
      read_word(AW'(a), d, v);
      check("cleared_data", d, 32'h0);
      check("cleared_valid", 32'(v), 32'd1);
    end

    write_word(4'd5, 32'hAABBCCDD, 4'b1111);
    write_word(4'd5, 32'h11223344, 4'b0101);
    read_word(4'd5, d, v);
    check("lane_write", d, 32'hAA22CC44);

    write_word(4'd7, 32'hDEADBEEF, 4'b0000);
    read_word(4'd7, d, v);
    check("zero_lane_noop", d, 32'h0);

    write_word(4'd3, 32'h01020304, 4'b1111);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hFFFFFFFF; wr_lane_en = 4'b1000;
    rd_en = 1'b1; rd_addr = 4'd3;
    cycle();
    idle();
    for (int i = 1; i < LAT; i++) cycle();
    check("rdw_data", rd_data, 32'hFF020304);
    check("rdw_valid", 32'(rd_valid), 32'd1);
    cycle();

    clear_req = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h12345678; wr_lane_en = 4'b1111;
    rd_en = 1'b1; rd_addr = 4'd2;
    cycle();
    idle();
    check("clr_prec_valid", 32'(rd_valid), 32'd0);
    wait_sweep("req_sweep_len");
    read_word(4'd2, d, v);
    check("clr_prec_addr2", d, 32'h0);

    clear_req = 1'b1;
    cycle();
    idle();
    for (int i = 0; i < 6; i++) cycle();
    do_reset();
    rd_en = 1'b1;
    begin
      int bc = 0;
      while (busy && bc < 40) begin
        rd_addr = AW'($urandom_range(DEPTH - 1));
        cycle();
        check("sweep_rd_valid", 32'(rd_valid), 32'd0);
        bc++;
      end
      check("midreset_sweep_len", 32'(bc), 32'(DEPTH));
    end
    idle();

    write_word(4'd1, 32'h10101010, 4'b1111);
    write_word(4'd2, 32'h20202020, 4'b1111);
    write_word(4'd3, 32'h30303030, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1; rd_addr = AW'(i + 1);
      cycle();
      log_d[i] = rd_data; log_v[i] = rd_valid;
    end
    idle();
    for (int i = 3; i < 6; i++) begin
      cycle();
      log_d[i] = rd_data; log_v[i] = rd_valid;
    end
    for (int i = 0; i < 3; i++) begin
      check("b2b_data", log_d[LAT - 1 + i], 32'h10101010 * (i + 1));
      check("b2b_valid", 32'(log_v[LAT - 1 + i]), 32'd1);
    end

    for (int n = 0; n < 600; n++) begin
      wr_en      = 1'($urandom_range(1));
      wr_addr    = AW'($urandom_range(DEPTH - 1));
      wr_lane_en = LN'($urandom_range(15));
      wr_data    = $urandom;
      rd_en      = 1'($urandom_range(1));
      rd_addr    = ($urandom_range(3) == 0) ? wr_addr : AW'($urandom_range(DEPTH - 1));
      clear_req  = ($urandom_range(79) == 0);
      cycle();
    end
    idle();
    for (int i = 0; i < 20; i++) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/vector_bank_ram.md
Name: vector_bank_ram

Overview:
- Parametrised successor to the team's single-port RAM: one write port, one read port, data split into LANES lanes with per-lane write enables.
- Synchronous registered read with valid flag and read-during-write forwarding.
- Hardware clear engine zeroes the whole array after reset or on request.
- Sits under the VPU vector register file and lane scratch buffers.

Parameters:
ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH entries
LANES, 4, number of independently writable lanes per word
LANE_WIDTH, 8, bits per lane; DATA_WIDTH = LANES*LANE_WIDTH
CLEAR_ON_RESET, 1, 1 = start clear sweep on reset release; 0 = come up READY with memory contents undefined

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_addr  in  ADDR_WIDTH  write address
wr_lane_en  in  LANES  per-lane write enable; bit i covers wr_data[i*LANE_WIDTH +: LANE_WIDTH]
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read request
rd_addr  in  ADDR_WIDTH  read address
rd_data  out  DATA_WIDTH  registered read data
rd_valid  out  1  rd_data valid this cycle
clear_req  in  1  pulse: start full-array clear sweep
busy  out  1  clear sweep in progress

Behaviour:
- Reset (async assert, sync-released by the system):
  - rd_data = 0, rd_valid = 0, clear counter = 0.
  - State = CLEAR if CLEAR_ON_RESET, else READY; busy reflects the state immediately.
- FSM states: READY, CLEAR.
  - READY -> CLEAR on clear_req = 1.
  - CLEAR -> READY on the cycle the counter write hits DEPTH-1.
- CLEAR state:
  - Writes 0 to mem[cnt] each cycle; cnt increments from 0.
  - Sweep takes exactly DEPTH cycles; busy = 1 throughout, 0 from the first READY cycle.
  - External wr_en/rd_en are ignored (dropped, not queued); rd_valid = 0; rd_data holds its last value.
  - clear_req while in CLEAR is ignored; the sweep does not restart.
  - rst_n asserted mid-sweep aborts it; on release the sweep restarts from 0 if CLEAR_ON_RESET.
- READY write:
  - On wr_en, lane i of mem[wr_addr] is updated iff wr_lane_en[i]; other lanes keep their value.
  - wr_en with wr_lane_en = 0 is a no-op.
- READY read:
  - Read latency 1. rd_en at cycle N gives rd_data and rd_valid = 1 at cycle N+1.
  - rd_valid = 0 in any cycle following rd_en = 0; rd_data then holds its last value.
- Read-during-write, same address, same cycle:
  - Enabled lanes return the new wr_data (write-first forwarding).
  - Disabled lanes return the old memory content.
  - Different addresses: no interaction.
- Address wrap: none needed; addresses are full-range by construction.
- clear_req with simultaneous wr_en/rd_en in READY:
  - clear_req wins.
  - That cycle's write and read are dropped and rd_valid is 0 next cycle.

Optional Feature:
Macro VBRAM_OUT_REG_EN.
- Defined: adds a second output register stage.
  - Read latency 2; rd_valid is pipelined alongside the data.
  - Forwarding is still resolved at stage 1; both stages clear to 0 on reset.
  - Any in-flight read in stage 2 still completes when a clear starts.
- Undefined: latency 1 as above.

Decomposition:
- Package vpu_mem_pkg holds:
  - typedef enum {READY, CLEAR} vbram_state_e
  - localparams for DATA_WIDTH derivation
  - a lane_mask function that expands LANES enables to DATA_WIDTH bitmask
- One sub-module, vbram_clear_ctrl: FSM + counter; outputs busy, clear_we and clear_addr.
- Storage array and read pipeline stay in the top module.

Test Plan:
- Clear after reset: CLEAR_ON_RESET = 1, ADDR_WIDTH = 4; release rst_n.
  -> busy = 1 for exactly 16 cycles.
  -> Then read addr 0..15 returns 0x00000000 with rd_valid one cycle after each rd_en.
- Lane write: write 0xAABBCCDD to addr 5 all lanes, then write 0x11223344 with wr_lane_en = 4'b0101.
  -> Read addr 5 returns 0xAA22CC44.
- Read-during-write: mem[3] = 0x01020304; same cycle wr 0xFFFFFFFF lanes 4'b1000 and rd addr 3.
  -> Next cycle rd_data = 0xFF020304, rd_valid = 1.
- Clear precedence: in READY, clear_req + wr_en (addr 2, 0x12345678) + rd_en in the same cycle.
  -> rd_valid = 0 next cycle.
  -> After the sweep, addr 2 reads 0.
- Reset mid-sweep: assert rst_n = 0 at sweep cycle 7, release.
  -> Sweep restarts; busy = 1 for a full 16 cycles.
  -> rd_en during the sweep gives rd_valid = 0.
- VBRAM_OUT_REG_EN defined: back-to-back reads of addr 1, 2, 3 (distinct data).
  -> Data appears in order at cycles N+2, N+3, N+4, each with rd_valid = 1.
